// File: rtl/acc_csr_ctrl.sv
// -----------------------------------------------------------------------------
// acc_csr_ctrl
//
// Avalon-MM CSR front end for the custom accelerator. HPS software writes
// START to launch a run; the block emits a single-cycle start pulse, times
// the run in clock cycles, captures the accelerator's finish pulse, keeps a
// saturating run counter, flags timeouts and raises a level interrupt.
//
// Bus handshake: the slave is always ready (no waitrequest). A write is
// accepted on every clk edge where avs_write = 1. A read is accepted on every
// clk edge where avs_read = 1 and its data appears on avs_readdata in the
// following cycle (fixed latency 1); avs_readdata holds until the next read.
//
// CSR map (32-bit words, unused bits read 0):
//   0 CTRL   : [0] START (write 1 = request, reads 0), [1] IRQ_EN (RW)
//   1 STATUS : [0] BUSY (RO), [1] DONE (W1C), [2] TIMEOUT_ERR (W1C),
//              [3] START_IGNORED (W1C)
//   2 CYCLES : cycle count of the last completed run (RO)
//   3 RUNS   : runs completed via i_finish (RO, any write clears)
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   avs_address    CSR word address
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_read       read strobe
//   avs_readdata   registered read data (latency 1)
//   irq            level interrupt, IRQ_EN & (DONE | TIMEOUT_ERR), registered
//   o_start        single-cycle start pulse to the accelerator
//   i_finish       finish pulse from the accelerator
// -----------------------------------------------------------------------------
module acc_csr_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 60000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic        o_start,
    input  logic        i_finish
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CYCLES = 2'd2;
    localparam logic [1:0] ADDR_RUNS   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // FSM state, kept as a named signal so checkers can bind to it.
    state_t state;
    state_t state_nxt;

    // CSR storage
    logic             irq_en;
    logic             done;
    logic             timeout_err;
    logic             start_ignored;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] runs_q;

    // Write decode
    logic wr_ctrl;
    logic wr_status;
    logic wr_runs;
    logic start_req;

    // FSM events
    logic start_go;
    logic finish_evt;
    logic timeout_evt;
    logic start_ign;

    // Datapath helpers
    logic             busy;
    logic [CNT_W-1:0] cyc_cnt_inc;
    logic [CNT_W-1:0] runs_inc;
    logic [31:0]      rd_mux;

    // Only the low nibble of the write data carries CSR bits.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:4];

    assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
    assign wr_status = avs_write && (avs_address == ADDR_STATUS);
    assign wr_runs   = avs_write && (avs_address == ADDR_RUNS);
    assign start_req = wr_ctrl && avs_writedata[0];

    assign busy = (state == ST_BUSY);

    // Both counters stick at all-ones instead of wrapping.
    assign cyc_cnt_inc = (cyc_cnt == CNT_MAX) ? cyc_cnt : cyc_cnt + CNT_ONE;
    assign runs_inc    = (runs_q  == CNT_MAX) ? runs_q  : runs_q  + CNT_ONE;

    // -------------------------------------------------------------------------
    // FSM next-state and event decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        start_go    = 1'b0;
        finish_evt  = 1'b0;
        timeout_evt = 1'b0;
        start_ign   = 1'b0;

        case (state)
            ST_IDLE: begin
                // A finish pulse while idle is deliberately ignored.
                if (start_req) begin
                    start_go  = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // Starting is only possible from IDLE, so o_start can never
                // be high on two consecutive cycles.
                if (start_req) begin
                    start_ign = 1'b1;
                end
                // Finish has priority over a timeout on the same cycle.
                if (i_finish) begin
                    finish_evt = 1'b1;
                    state_nxt  = ST_IDLE;
                end else if (cyc_cnt == TIMEOUT_CNT) begin
                    timeout_evt = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Read data mux
    // -------------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL:   rd_mux = {30'd0, irq_en, 1'b0};
            ADDR_STATUS: rd_mux = {28'd0, start_ignored, timeout_err, done, busy};
            ADDR_CYCLES: rd_mux = 32'(cycles_q);
            ADDR_RUNS:   rd_mux = 32'(runs_q);
            default:     rd_mux = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and CSR registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            o_start       <= 1'b0;
            irq           <= 1'b0;
            avs_readdata  <= '0;
            irq_en        <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            start_ignored <= 1'b0;
            cyc_cnt       <= '0;
            cycles_q      <= '0;
            runs_q        <= '0;
        end else begin
            state   <= state_nxt;
            o_start <= start_go;

            // Built from the registered flags, so irq lags them by one cycle.
            irq <= irq_en & (done | timeout_err);

            if (wr_ctrl) begin
                irq_en <= avs_writedata[1];
            end

            // The counter is 0 during the o_start cycle and counts up on
            // every following busy cycle.
            if (start_go) begin
                cyc_cnt <= '0;
            end else if (busy) begin
                cyc_cnt <= cyc_cnt_inc;
            end

            // Hardware set beats a software W1C on the same edge.
            if (finish_evt) begin
                done <= 1'b1;
            end else if (start_go || (wr_status && avs_writedata[1])) begin
                done <= 1'b0;
            end

            if (timeout_evt) begin
                timeout_err <= 1'b1;
            end else if (start_go || (wr_status && avs_writedata[2])) begin
                timeout_err <= 1'b0;
            end

            if (start_ign) begin
                start_ignored <= 1'b1;
            end else if (wr_status && avs_writedata[3]) begin
                start_ignored <= 1'b0;
            end

            if (finish_evt) begin
                cycles_q <= cyc_cnt;
            end

            // A completing run is never lost to a simultaneous clear.
            if (finish_evt) begin
                runs_q <= runs_inc;
            end else if (wr_runs) begin
                runs_q <= '0;
            end

            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_acc_csr_ctrl.sv
module tb_acc_csr_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        irq;
    logic        o_start;
    logic        i_finish;

    int n_cmp  = 0;
    int n_fail = 0;

    // Read scoreboard
    logic [31:0] exp_q[$];
    string       tag_q[$];

    // Accelerator stub state
    int stub_delay   = 0;   // 0 = never finish
    int stub_cnt     = 0;
    bit stub_active  = 0;
    int start_pulses = 0;
    bit prev_start   = 0;
    bit double_start = 0;
    int snap_pulses  = 0;

    acc_csr_ctrl #(
        .TIMEOUT_CYCLES(20),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avs_address(avs_address),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_read(avs_read),
        .avs_readdata(avs_readdata),
        .irq(irq),
        .o_start(o_start),
        .i_finish(i_finish)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accelerator stub: raises i_finish stub_delay cycles after the o_start
    // cycle, counts start pulses and flags back-to-back starts.
    initial begin
        i_finish = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (o_start === 1'b1 && prev_start) double_start = 1'b1;
            prev_start = (o_start === 1'b1);
            i_finish = 1'b0;
            if (stub_active) begin
                stub_cnt++;
                if (stub_cnt == stub_delay) begin
                    i_finish    = 1'b1;
                    stub_active = 1'b0;
                end
            end
            if (o_start === 1'b1) begin
                stub_active = 1'b1;
                stub_cnt    = 0;
                start_pulses++;
            end
        end
    end

    // Driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        step(1);
        avs_write     = 1'b0;
        avs_writedata = '0;
    endtask

    task automatic csr_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        avs_address = a;
        avs_read    = 1'b1;
        step(1);
        avs_read    = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, avs_readdata, e);
    endtask

    initial begin
        reset_n       = 1'b0;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        step(3);
        reset_n = 1'b1;

        // Reset state
        check("rst_o_start", {31'd0, o_start}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        csr_read(2'd0, 32'd0, "rst_ctrl");
        csr_read(2'd1, 32'd0, "rst_status");
        csr_read(2'd2, 32'd0, "rst_cycles");
        csr_read(2'd3, 32'd0, "rst_runs");

        // 1: 10-cycle run with IRQ_EN, START + IRQ_EN in one write
        stub_delay  = 10;
        snap_pulses = start_pulses;
        csr_write(2'd0, 32'h3);
        check("t1_start_hi", {31'd0, o_start}, 32'd1);
        step(1);
        check("t1_start_lo", {31'd0, o_start}, 32'd0);
        step(10);
        check("t1_irq_lag", {31'd0, irq}, 32'd0);
        csr_read(2'd1, 32'h2, "t1_status");
        check("t1_irq", {31'd0, irq}, 32'd1);
        csr_read(2'd2, 32'd10, "t1_cycles");
        csr_read(2'd3, 32'd1, "t1_runs");
        csr_read(2'd0, 32'h2, "t1_ctrl");
        check("t1_pulses", 32'(start_pulses - snap_pulses), 32'd1);
        csr_write(2'd1, 32'h2);
        check("t1_irq_hold", {31'd0, irq}, 32'd1);
        step(1);
        check("t1_irq_clr", {31'd0, irq}, 32'd0);
        csr_read(2'd1, 32'h0, "t1_status_clr");

        // 2: timeout at counter 20, then a new START clears TIMEOUT_ERR
        stub_delay = 0;
        csr_write(2'd0, 32'h3);
        step(20);
        csr_read(2'd1, 32'h1, "t2_busy_at_20");
        csr_read(2'd1, 32'h4, "t2_timeout");
        check("t2_irq", {31'd0, irq}, 32'd1);
        csr_read(2'd2, 32'd10, "t2_cycles_keep");
        csr_read(2'd3, 32'd1, "t2_runs_keep");
        stub_delay = 5;
        csr_write(2'd0, 32'h3);
        csr_read(2'd1, 32'h1, "t2_restart_status");
        check("t2_irq_drop", {31'd0, irq}, 32'd0);
        step(5);
        csr_read(2'd2, 32'd5, "t2_cycles5");
        csr_read(2'd3, 32'd2, "t2_runs2");
        csr_write(2'd1, 32'h2);

        // 3: START while busy is ignored
        stub_delay  = 10;
        snap_pulses = start_pulses;
        csr_write(2'd0, 32'h1);
        step(3);
        csr_write(2'd0, 32'h1);
        check("t3_no_restart", {31'd0, o_start}, 32'd0);
        step(7);
        csr_read(2'd1, 32'hA, "t3_status");
        csr_read(2'd2, 32'd10, "t3_cycles");
        csr_read(2'd3, 32'd3, "t3_runs");
        check("t3_pulses", 32'(start_pulses - snap_pulses), 32'd1);
        check("t3_irq_off", {31'd0, irq}, 32'd0);
        csr_write(2'd1, 32'hA);
        csr_read(2'd1, 32'h0, "t3_status_clr");

        // 4: finish exactly at the timeout count
        stub_delay = 20;
        csr_write(2'd0, 32'h1);
        step(21);
        csr_read(2'd1, 32'h2, "t4_status");
        csr_read(2'd2, 32'd20, "t4_cycles");
        csr_read(2'd3, 32'd4, "t4_runs");
        csr_write(2'd1, 32'h2);

        // W1C of DONE on the edge that sets it: set wins
        stub_delay = 4;
        csr_write(2'd0, 32'h1);
        step(4);
        csr_write(2'd1, 32'h2);
        csr_read(2'd1, 32'h2, "w1c_race_status");
        csr_read(2'd3, 32'd5, "w1c_race_runs");

        // 5: reset in busy cycle 5; later finish arrives while idle
        stub_delay = 10;
        csr_write(2'd0, 32'h3);
        step(5);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check("t5_o_start", {31'd0, o_start}, 32'd0);
        check("t5_irq", {31'd0, irq}, 32'd0);
        check("t5_readdata", avs_readdata, 32'd0);
        step(6);
        check("t5_irq_late", {31'd0, irq}, 32'd0);
        csr_read(2'd0, 32'h0, "t5_ctrl");
        csr_read(2'd1, 32'h0, "t5_status");
        csr_read(2'd2, 32'd0, "t5_cycles");
        csr_read(2'd3, 32'd0, "t5_runs");

        // 6: back-to-back runs of 5 and 7 cycles, then clear RUNS
        snap_pulses = start_pulses;
        stub_delay  = 5;
        csr_write(2'd0, 32'h1);
        step(6);
        stub_delay = 7;
        csr_write(2'd0, 32'h1);
        step(8);
        csr_read(2'd0, 32'h0, "t6_ctrl");
        csr_read(2'd1, 32'h2, "t6_status");
        csr_read(2'd2, 32'd7, "t6_cycles");
        csr_read(2'd3, 32'd2, "t6_runs");
        check("t6_pulses", 32'(start_pulses - snap_pulses), 32'd2);
        csr_write(2'd3, 32'h5A);
        csr_read(2'd3, 32'd0, "t6_runs_clr");
        csr_read(2'd2, 32'd7, "t6_cycles_keep");

        check("no_double_start", {31'd0, double_start}, 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
